viterbi_link_ctrl: RTL and testbench

Frame-level sequencer for the encoder -> channel -> Viterbi decoder link. On start it generates a PRBS7 payload frame, appends trellis-terminating tail zeros, and drives the encoder enable. It schedules burst error injection into the channel and aligns the decoder enable with the channel register. It compares decoded bits against a delayed reference and reports bit-error and injection counts.

---
 rtl/viterbi_link_pkg.sv | 17 +
 rtl/viterbi_link_prbs7_gen.sv | 31 +++
 rtl/viterbi_link_ctrl.sv | 166 ++++++++++++++++
 tb/tb_viterbi_link_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_link_pkg.sv
// Shared types and constants for the Viterbi link frame sequencer.
package viterbi_link_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAYLOAD = 3'd1,
        TAIL    = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // PRBS7, x^7 + x^6 + 1, seeded all-ones so the first payload bit is 1
    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;  // x^7 term
    localparam int         PRBS7_TAP_LO = 5;  // x^6 term

endpackage

// File: rtl/viterbi_link_prbs7_gen.sv
// Fibonacci PRBS7 source; bit_o is the register MSB, valid in the current cycle.
module prbs7_gen
    import viterbi_link_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic bit_o
);

    logic [6:0] lfsr_q, lfsr_d;

    // load re-seeds for a new frame; advance shifts one step
    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = PRBS7_SEED;
        else if (advance)
            lfsr_d = {lfsr_q[5:0], lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO]};
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= PRBS7_SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign bit_o = lfsr_q[6];

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer: PRBS payload + tail to the encoder, burst error injection,
// decoder enable alignment and bit-error / injection counting.
module viterbi_link_ctrl
    import viterbi_link_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 32,
    parameter int ERR_N     = 5,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             err_en_i,
    input  logic [1:0]       err_mask_i,
    output logic             enc_data_o,
    output logic             enc_enable_o,
    input  logic             enc_valid_i,
    output logic [1:0]       err_inj_o,
    output logic             dec_enable_o,
    input  logic             dec_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] bit_err_ct_o,
    output logic [CNT_W-1:0] inj_ct_o
);

    localparam int               WC_W       = 16;
    localparam logic [31:0]      PAY_LAST   = 32'(FRAME_LEN - 1);
    localparam logic [31:0]      TAIL_LAST  = 32'(TAIL_LEN - 1);
    localparam logic [31:0]      DRAIN_LAST = 32'(DEC_LAT - 1);
    localparam logic [WC_W-1:0]  WC_MAX     = WC_W'(FRAME_LEN);

    state_t             state_q, state_d;
    logic [31:0]        ph_q, ph_d;
    logic               pay_q, pay_d, enc_en_q, enc_en_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               err_en_q, err_en_d;
    logic [1:0]         mask_q, mask_d, inj_q, inj_d;
    logic               dec_en_q;
    logic [WC_W-1:0]    wc_q, wc_d;
    logic [CNT_W-1:0]   be_q, be_d, ic_q, ic_d;
    logic [DEC_LAT-1:0] ref_flag_q, ref_flag_d, ref_bit_q, ref_bit_d;
    logic               start_go, prbs_bit, in_frame, burst_hit, mismatch;

    prbs7_gen u_prbs (
        .clk     (clk),
        .rst     (rst),
        .load    (start_go),
        .advance (pay_q),
        .bit_o   (prbs_bit)
    );

    assign start_go  = (state_q == IDLE) && start_i;
    assign in_frame  = (state_q != IDLE);
    assign burst_hit = &wc_q[ERR_N-1:1];
    assign mismatch  = ref_flag_q[DEC_LAT-1] && (dec_data_i != ref_bit_q[DEC_LAT-1]);

    // Next state, registered-output decode, injection and counter updates
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = PAYLOAD;
                ph_d    = '0;
            end
            PAYLOAD: if (ph_q == PAY_LAST) begin
                state_d = (TAIL_LEN > 0) ? TAIL : DRAIN;
                ph_d    = '0;
            end else ph_d = ph_q + 32'd1;
            TAIL: if (ph_q == TAIL_LAST) begin
                state_d = DRAIN;
                ph_d    = '0;
            end else ph_d = ph_q + 32'd1;
            DRAIN: if (ph_q == DRAIN_LAST) begin
                state_d = DONE;
                ph_d    = '0;
            end else ph_d = ph_q + 32'd1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pay_d    = (state_d == PAYLOAD);
        enc_en_d = pay_d || (state_d == TAIL);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);

        err_en_d = start_go ? err_en_i   : err_en_q;
        mask_d   = start_go ? err_mask_i : mask_q;

        wc_d = wc_q;
        if (start_go)
            wc_d = '0;
        else if (in_frame && enc_valid_i && (wc_q < WC_MAX))
            wc_d = wc_q + WC_W'(1);

        inj_d = '0;
        if (in_frame && err_en_q && (wc_q < WC_MAX) && burst_hit && enc_valid_i)
            inj_d = mask_q;

        be_d = be_q;
        if (start_go)
            be_d = '0;
        else if (mismatch && (be_q != '1))
            be_d = be_q + CNT_W'(1);

        ic_d = ic_q;
        if (start_go)
            ic_d = '0;
        else if ((inj_q != 2'b00) && (ic_q != '1))
            ic_d = ic_q + CNT_W'(1);

        // Only payload bits carry a compare flag; tail and idle bits ride along unchecked
        ref_flag_d = (ref_flag_q << 1) | DEC_LAT'(pay_q);
        ref_bit_d  = (ref_bit_q  << 1) | DEC_LAT'(enc_data_o);
    end

    // Single state/output register bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            pay_q      <= 1'b0;
            enc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_en_q   <= 1'b0;
            mask_q     <= '0;
            inj_q      <= '0;
            dec_en_q   <= 1'b0;
            wc_q       <= '0;
            be_q       <= '0;
            ic_q       <= '0;
            ref_flag_q <= '0;
            ref_bit_q  <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            pay_q      <= pay_d;
            enc_en_q   <= enc_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_en_q   <= err_en_d;
            mask_q     <= mask_d;
            inj_q      <= inj_d;
            dec_en_q   <= enc_valid_i;
            wc_q       <= wc_d;
            be_q       <= be_d;
            ic_q       <= ic_d;
            ref_flag_q <= ref_flag_d;
            ref_bit_q  <= ref_bit_d;
        end
    end

    assign enc_data_o   = pay_q & prbs_bit;
    assign enc_enable_o = enc_en_q;
    assign err_inj_o    = inj_q;
    assign dec_enable_o = dec_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign bit_err_ct_o = be_q;
    assign inj_ct_o     = ic_q;

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Self-checking bench for viterbi_link_ctrl: table of frame configurations plus
// hand sequences for held start and mid-frame reset.
module tb_viterbi_link_ctrl;

    localparam int FRAME_LEN = 256;
    localparam int TAIL_LEN  = 2;
    localparam int DEC_LAT   = 32;
    localparam int DONE_CYC  = 1 + FRAME_LEN + TAIL_LEN + DEC_LAT;  // 291

    logic        clk = 1'b0;
    logic        rst, start_i, err_en_i, enc_valid_i, dec_data_i;
    logic [1:0]  err_mask_i;
    logic        enc_data_o, enc_enable_o, dec_enable_o, busy_o, done_o;
    logic [1:0]  err_inj_o;
    logic [15:0] bit_err_ct_o, inj_ct_o;
    logic        enc_data_8, enc_enable_8, dec_enable_8, busy_8, done_8;
    logic [1:0]  err_inj_8;
    logic [7:0]  bit_err_8, inj_ct_8;

    always #5 clk = ~clk;

    viterbi_link_ctrl u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .err_en_i(err_en_i), .err_mask_i(err_mask_i),
        .enc_data_o(enc_data_o), .enc_enable_o(enc_enable_o), .enc_valid_i(enc_valid_i),
        .err_inj_o(err_inj_o), .dec_enable_o(dec_enable_o), .dec_data_i(dec_data_i),
        .busy_o(busy_o), .done_o(done_o), .bit_err_ct_o(bit_err_ct_o), .inj_ct_o(inj_ct_o)
    );

    viterbi_link_ctrl #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start_i), .err_en_i(err_en_i), .err_mask_i(err_mask_i),
        .enc_data_o(enc_data_8), .enc_enable_o(enc_enable_8), .enc_valid_i(enc_valid_i),
        .err_inj_o(err_inj_8), .dec_enable_o(dec_enable_8), .dec_data_i(dec_data_i),
        .busy_o(busy_8), .done_o(done_8), .bit_err_ct_o(bit_err_8), .inj_ct_o(inj_ct_8)
    );

    typedef struct {
        logic       en;
        logic [1:0] mask;
        logic       inv;
        int         exp_be;
        int         exp_be8;
        int         exp_inj;
    } vec_t;

    vec_t               vecs [5];
    int                 checks = 0;
    int                 failures = 0;
    logic               exp_bit_q [$];
    int                 exp_inj_q [$];
    logic [DEC_LAT-1:0] bdl;
    logic               en_prev, vld_prev;
    logic               cap [0:FRAME_LEN-1];
    logic               busy_hist [0:511];
    int                 done_cnt, done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference payload: PRBS7 x^7+x^6+1 from seed 7F, then zero tail
    task automatic push_expected_bits();
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < FRAME_LEN; i++) begin
            exp_bit_q.push_back(s[6]);
            s = {s[5:0], s[6] ^ s[5]};
        end
        for (int i = 0; i < TAIL_LEN; i++) exp_bit_q.push_back(1'b0);
    endtask

    // One frame: start at cyc 0, loop dec_data_i from enc_data_o, check every cycle up to DONE
    task automatic run_frame(input logic en, input logic [1:0] mask, input logic inv,
                             input logic hold, input int ncyc);
        logic       exp_en, exp_d;
        logic [1:0] exp_inj;
        exp_bit_q.delete();
        exp_inj_q.delete();
        push_expected_bits();
        // valid at cycle c carries wc = c-2; injection shows one cycle later
        if (en && mask != 2'b00)
            for (int w = 0; w < FRAME_LEN; w++)
                if (w[4:1] == 4'hF) exp_inj_q.push_back(w + 3);
        bdl = '0; en_prev = 1'b0; done_cnt = 0; done_cyc = -1;
        for (int cyc = 0; cyc <= ncyc; cyc++) begin
            @(posedge clk); #1;
            start_i     = (cyc == 0) || hold;
            err_en_i    = (cyc == 0) ? en : ~en;      // must be latched only at start
            err_mask_i  = (cyc == 0) ? mask : ~mask;
            vld_prev    = enc_valid_i;
            enc_valid_i = en_prev;
            dec_data_i  = bdl[DEC_LAT-1] ^ inv;
            @(negedge clk);
            exp_en = (cyc >= 1) && (cyc <= FRAME_LEN + TAIL_LEN);
            if (cyc <= DONE_CYC) begin
                exp_d = 1'b0;
                if (exp_en) exp_d = exp_bit_q.pop_front();
                chk("enc_en_data", {enc_enable_o, enc_data_o}, {exp_en, exp_d});
                chk("busy_done", {busy_o, done_o}, {(cyc >= 1 && cyc <= DONE_CYC), (cyc == DONE_CYC)});
                exp_inj = 2'b00;
                if (exp_inj_q.size() > 0 && exp_inj_q[0] == cyc) begin
                    exp_inj = mask;
                    void'(exp_inj_q.pop_front());
                end
                chk("err_inj", err_inj_o, exp_inj);
                chk("dec_enable", dec_enable_o, vld_prev);
            end
            if (exp_en && cyc <= FRAME_LEN) cap[cyc-1] = enc_data_o;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc < 512) busy_hist[cyc] = busy_o;
            en_prev = enc_enable_o;
            bdl = {bdl[DEC_LAT-2:0], enc_data_o};
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_outs"}, {enc_data_o, enc_enable_o, err_inj_o, dec_enable_o, busy_o, done_o}, 0);
        chk({name, "_cnts"}, {bit_err_ct_o, inj_ct_o}, 0);
        chk({name, "_outs8"}, {enc_data_8, enc_enable_8, err_inj_8, dec_enable_8, busy_8, done_8,
                               bit_err_8, inj_ct_8}, 0);
    endtask

    task automatic check_period();
        int bad;
        bad = 0;
        for (int k = 0; k < 127; k++) if (cap[k] !== cap[k+127]) bad++;
        chk("prbs_period", bad, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'b00, 1'b0,   0,   0,  0};
        vecs[1] = '{1'b1, 2'b01, 1'b0,   0,   0, 16};
        vecs[2] = '{1'b1, 2'b00, 1'b0,   0,   0,  0};
        vecs[3] = '{1'b0, 2'b10, 1'b1, 256, 255,  0};
        vecs[4] = '{1'b1, 2'b11, 1'b1, 256, 255, 16};

        rst = 1'b0; start_i = 1'b0; err_en_i = 1'b0; err_mask_i = 2'b00;
        enc_valid_i = 1'b0; dec_data_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].en, vecs[i].mask, vecs[i].inv, 1'b0, DONE_CYC + 4);
            chk("done_count", done_cnt, 1);
            chk("done_cycle", done_cyc, DONE_CYC);
            chk("bit_err_ct", bit_err_ct_o, vecs[i].exp_be);
            chk("bit_err_ct_w8", bit_err_8, vecs[i].exp_be8);
            chk("inj_ct", inj_ct_o, vecs[i].exp_inj);
            chk("inj_sb_empty", exp_inj_q.size(), 0);
            check_period();
        end

        // start held through the whole frame: one DONE, then restart from the next IDLE cycle
        run_frame(1'b0, 2'b00, 1'b0, 1'b1, DONE_CYC + 3);
        start_i = 1'b0;
        chk("hold_done_count", done_cnt, 1);
        chk("hold_busy_idle", busy_hist[DONE_CYC+1], 0);
        chk("hold_busy_restart", busy_hist[DONE_CYC+2], 1);
        @(posedge clk); #1 rst = 1'b0;
        #1 check_all_zero("reset_hold");
        enc_valid_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // reset at payload cycle 100 with injection active, then a clean frame from the seed
        run_frame(1'b1, 2'b11, 1'b0, 1'b0, 100);
        rst = 1'b0;
        #1 check_all_zero("reset_mid");
        enc_valid_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        run_frame(1'b0, 2'b00, 1'b0, 1'b0, DONE_CYC + 4);
        chk("post_rst_done_count", done_cnt, 1);
        chk("post_rst_bit_err", bit_err_ct_o, 0);
        chk("post_rst_inj_ct", inj_ct_o, 0);
        check_period();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
